// File: rtl/loteria_n.sv
// Two-player lottery: load a draw of N_PICKS numbers, then each player guesses in turn.
// Optional duplicate-guess rejection is compiled in with `define LOTERIA_DUP_REJECT_EN.
module loteria_n #(
  parameter int NUM_W   = 4,
  parameter int N_PICKS = 5,
  parameter int CNT_W   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NUM_W-1:0] numero,
  input  logic             insere,
  input  logic             fim,
  input  logic             fim_jogo,
  output logic [1:0]       premio,
  output logic [CNT_W-1:0] p1,
  output logic [CNT_W-1:0] p2,
  output logic [1:0]       estado,
  output logic             dup
);

  typedef enum logic [1:0] {
    CARGA  = 2'b00,
    J1     = 2'b01,
    J2     = 2'b10,
    RESULT = 2'b11
  } state_t;

  localparam logic [3:0]       LAST_IDX  = 4'(N_PICKS - 1);
  localparam logic [CNT_W-1:0] SCORE_MAX = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [N_PICKS-1:0] hit_q, hit_d;
  logic [N_PICKS-1:0] hit_new_s;
  logic [CNT_W-1:0]   p1_q, p1_d, p2_q, p2_d;
  logic [1:0]         premio_q, premio_d;
  logic               dup_q, dup_d;
  logic               is_dup_s;
  logic               turn_end_s;
  logic [NUM_W-1:0]   draw_q [N_PICKS];

  function automatic logic [1:0] judge(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    if (a > b) begin
      judge = 2'b01;
    end else if (b > a) begin
      judge = 2'b10;
    end else begin
      judge = 2'b11;
    end
  endfunction

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] s);
    if (s == SCORE_MAX) begin
      bump = s;
    end else begin
      bump = s + CNT_W'(1);
    end
  endfunction

`ifdef LOTERIA_DUP_REJECT_EN
  logic [NUM_W-1:0] hist_q [N_PICKS];

  // history only holds entries below idx_q, so clearing idx_q at turn start empties it
  always_ff @(posedge clock) begin
    if (!reset && (state_q == J1 || state_q == J2) && insere && !is_dup_s) begin
      for (int i = 0; i < N_PICKS; i++) begin
        if (idx_q == 4'(i)) hist_q[i] <= numero;
      end
    end
  end

  always_comb begin
    is_dup_s = 1'b0;
    for (int i = 0; i < N_PICKS; i++) begin
      if ((4'(i) < idx_q) && (hist_q[i] == numero)) is_dup_s = 1'b1;
    end
  end
`else
  assign is_dup_s = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset && state_q == CARGA && insere) begin
      for (int i = 0; i < N_PICKS; i++) begin
        if (idx_q == 4'(i)) draw_q[i] <= numero;
      end
    end
  end

  // a slot scores only once per turn, so repeated draw values are all marked together
  always_comb begin
    hit_new_s = '0;
    for (int i = 0; i < N_PICKS; i++) begin
      hit_new_s[i] = (draw_q[i] == numero) && !hit_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hit_d      = hit_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    premio_d   = 2'b00;
    dup_d      = 1'b0;
    turn_end_s = 1'b0;
    case (state_q)
      CARGA: begin
        if (insere) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == LAST_IDX) begin
            state_d = J1;
            idx_d   = 4'd0;
            hit_d   = '0;
          end
        end
      end
      J1, J2: begin
        turn_end_s = fim || (state_q == J2 && fim_jogo);
        if (insere) begin
          if (is_dup_s) begin
            dup_d = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
            hit_d = hit_q | hit_new_s;
            if (|hit_new_s) begin
              if (state_q == J1) p1_d = bump(p1_q);
              else               p2_d = bump(p2_q);
            end
            if (idx_q == LAST_IDX) turn_end_s = 1'b1;
          end
        end
        // the final guess is already folded into p1_d/p2_d before judging
        if (turn_end_s) begin
          idx_d = 4'd0;
          hit_d = '0;
          if (state_q == J1) begin
            state_d = J2;
          end else begin
            state_d  = RESULT;
            premio_d = judge(p1_d, p2_d);
          end
        end
      end
      RESULT: begin
        premio_d = premio_q;
      end
      default: begin
        state_d = CARGA;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= CARGA;
      idx_q    <= 4'd0;
      hit_q    <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      premio_q <= 2'b00;
      dup_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hit_q    <= hit_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      premio_q <= premio_d;
      dup_q    <= dup_d;
    end
  end

  assign premio = premio_q;
  assign p1     = p1_q;
  assign p2     = p2_q;
  assign estado = state_q;
  assign dup    = dup_q;

endmodule

// File: tb/tb_loteria_n.sv
// Scoreboard bench for loteria_n: a behavioural game model predicts every output after each edge.
// Build with +define+LOTERIA_DUP_REJECT_EN to exercise duplicate rejection.
module tb_loteria_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b0, ins_a = 1'b0, fim_a = 1'b0, fj_a = 1'b0;
  logic [3:0] num_a = 4'd0;
  logic [1:0] premio_a, estado_a;
  logic [4:0] p1_a, p2_a;
  logic       dup_a;

  logic       rst_b = 1'b0, ins_b = 1'b0, fim_b = 1'b0, fj_b = 1'b0;
  logic [5:0] num_b = 6'd0;
  logic [1:0] premio_b, estado_b;
  logic [4:0] p1_b, p2_b;
  logic       dup_b;

  loteria_n dut (
    .clock(clk), .reset(rst_a), .numero(num_a), .insere(ins_a), .fim(fim_a),
    .fim_jogo(fj_a), .premio(premio_a), .p1(p1_a), .p2(p2_a), .estado(estado_a), .dup(dup_a)
  );

  loteria_n #(.NUM_W(6), .N_PICKS(8), .CNT_W(5)) dut6 (
    .clock(clk), .reset(rst_b), .numero(num_b), .insere(ins_b), .fim(fim_b),
    .fim_jogo(fj_b), .premio(premio_b), .p1(p1_b), .p2(p2_b), .estado(estado_b), .dup(dup_b)
  );

  typedef struct packed {
    logic [1:0] estado;
    logic [4:0] p1;
    logic [4:0] p2;
    logic [1:0] premio;
    logic       dup;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad   = 0;
  int sel   = 0;
  int stepno = 0;

  int m_state, m_cnt, m_p1, m_p2, m_premio, m_dup, m_n, m_max;
  int m_draw[16];
  int m_hist[16];
  bit m_hit[16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model(input logic r, input logic i, input int num, input logic f, input logic fj);
    bit endt, d, scored;
    if (r) begin
      m_state = 0; m_cnt = 0; m_p1 = 0; m_p2 = 0; m_premio = 0; m_dup = 0;
      for (int k = 0; k < 16; k++) m_hit[k] = 1'b0;
      return;
    end
    m_dup = 0;
    if (m_state != 3) m_premio = 0;
    if (m_state == 0) begin
      if (i) begin
        m_draw[m_cnt] = num;
        m_cnt++;
        if (m_cnt == m_n) begin
          m_state = 1; m_cnt = 0;
          for (int k = 0; k < 16; k++) m_hit[k] = 1'b0;
        end
      end
    end else if (m_state == 1 || m_state == 2) begin
      endt = f || (m_state == 2 && fj);
      if (i) begin
        d = 1'b0;
`ifdef LOTERIA_DUP_REJECT_EN
        for (int k = 0; k < m_cnt; k++) if (m_hist[k] == num) d = 1'b1;
`endif
        if (d) begin
          m_dup = 1;
        end else begin
          m_hist[m_cnt] = num;
          m_cnt++;
          scored = 1'b0;
          for (int k = 0; k < m_n; k++) begin
            if (m_draw[k] == num && !m_hit[k]) begin
              m_hit[k] = 1'b1;
              scored = 1'b1;
            end
          end
          if (scored) begin
            if (m_state == 1) begin
              if (m_p1 < m_max) m_p1++;
            end else begin
              if (m_p2 < m_max) m_p2++;
            end
          end
          if (m_cnt == m_n) endt = 1'b1;
        end
      end
      if (endt) begin
        m_cnt = 0;
        for (int k = 0; k < 16; k++) m_hit[k] = 1'b0;
        if (m_state == 1) begin
          m_state = 2;
        end else begin
          m_state = 3;
          m_premio = (m_p1 > m_p2) ? 1 : (m_p2 > m_p1) ? 2 : 3;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic i, input int num, input logic f, input logic fj);
    exp_t e, g;
    @(negedge clk);
    if (sel == 0) begin
      rst_a = r; ins_a = i; num_a = 4'(num); fim_a = f; fj_a = fj;
    end else begin
      rst_b = r; ins_b = i; num_b = 6'(num); fim_b = f; fj_b = fj;
    end
    model(r, i, num, f, fj);
    e.estado = 2'(m_state); e.p1 = 5'(m_p1); e.p2 = 5'(m_p2);
    e.premio = 2'(m_premio); e.dup = 1'(m_dup);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    stepno++;
    if (sel == 0) begin
      g.estado = estado_a; g.p1 = p1_a; g.p2 = p2_a; g.premio = premio_a; g.dup = dup_a;
    end else begin
      g.estado = estado_b; g.p1 = p1_b; g.p2 = p2_b; g.premio = premio_b; g.dup = dup_b;
    end
    e = sb_q.pop_front();
    check($sformatf("estado#%0d", stepno), 32'(g.estado), 32'(e.estado));
    check($sformatf("p1#%0d", stepno), 32'(g.p1), 32'(e.p1));
    check($sformatf("p2#%0d", stepno), 32'(g.p2), 32'(e.p2));
    check($sformatf("premio#%0d", stepno), 32'(g.premio), 32'(e.premio));
    check($sformatf("dup#%0d", stepno), 32'(g.dup), 32'(e.dup));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic guess(input int num);
    step(1'b0, 1'b1, num, 1'b0, 1'b0);
  endtask

  task automatic load_default();
    int draws[5] = '{5, 3, 8, 2, 0};
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b1, draws[0], 1'b0, 1'b1);
    step(1'b0, 1'b1, draws[1], 1'b1, 1'b0);
    for (int k = 2; k < 5; k++) guess(draws[k]);
  endtask

  initial begin
    int p2g[5] = '{8, 2, 7, 9, 11};
    m_n = 5; m_max = 31;

    // reset values, then a full winning turn for player 1
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    check("reset_estado", 32'(estado_a), 32'd0);
    check("reset_p1", 32'(p1_a), 32'd0);
    idle();
    load_default();
    check("load_to_j1", 32'(estado_a), 32'd1);
    guess(5); guess(3); guess(8); guess(2); guess(0);
    check("req031_p1", 32'(p1_a), 32'd5);
    check("req031_estado", 32'(estado_a), 32'd2);
    guess(8);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1);
    check("p1_wins_premio", 32'(premio_a), 32'd1);
    guess(3);
    idle();

    // early fim for player 1, player 2 finishes the game by count
    load_default();
    guess(1); guess(4);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) guess(p2g[k]);
    check("req032_p2", 32'(p2_a), 32'd2);
    check("req032_estado", 32'(estado_a), 32'd3);
    check("req032_premio", 32'(premio_a), 32'd2);

    // repeated guesses, then a tie via fim_jogo
    load_default();
    for (int k = 0; k < 5; k++) guess(5);
    check("req033_p1", 32'(p1_a), 32'd1);
`ifdef LOTERIA_DUP_REJECT_EN
    check("req033_still_j1", 32'(estado_a), 32'd1);
`else
    check("req033_to_j2", 32'(estado_a), 32'd2);
`endif
    if (m_state == 1) step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    guess(3);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1);
    check("req034_estado", 32'(estado_a), 32'd3);
    check("req034_premio", 32'(premio_a), 32'd3);

    // guess scored together with fim, then reset mid-turn in J2
    load_default();
    guess(5); guess(3);
    step(1'b0, 1'b1, 8, 1'b1, 1'b0);
    check("req021_p1", 32'(p1_a), 32'd3);
    check("req021_j2", 32'(estado_a), 32'd2);
    step(1'b1, 1'b1, 2, 1'b1, 1'b1);
    check("req035_p1", 32'(p1_a), 32'd0);
    check("req035_estado", 32'(estado_a), 32'd0);

    // wide configuration: fim_jogo ignored in J1
    sel = 1; m_n = 8;
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) guess(k);
    check("req036_loaded", 32'(estado_b), 32'd1);
    guess(63);
    step(1'b0, 1'b1, 7, 1'b0, 1'b1);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1);
    check("req036_fj_ignored", 32'(estado_b), 32'd1);
    guess(0);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    check("req036_p1", 32'(p1_b), 32'd2);
    check("req036_estado", 32'(estado_b), 32'd2);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/loteria_n.md
LOTERIA_N -- requirements
Module: loteria_n

Interface
REQ-001 Parameter NUM_W, default 4: bit width of each lottery number.
REQ-002 Parameter N_PICKS, default 5: numbers per draw and per player turn, range 1..15.
REQ-003 Parameter CNT_W, default 5: width of each score output, at least clog2(N_PICKS+1).
REQ-004 clock  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
REQ-006 numero  input  NUM_W  number presented with insere.
REQ-007 insere  input  1  one-cycle strobe; accept numero this cycle.
REQ-008 fim  input  1  end current player's turn early.
REQ-009 fim_jogo  input  1  end game; honoured only in state J2.
REQ-010 premio  output  2  00 game running, 01 player 1 wins, 10 player 2 wins, 11 tie.
REQ-011 p1  output  CNT_W  player 1 hit count.
REQ-012 p2  output  CNT_W  player 2 hit count.
REQ-013 estado  output  2  state code: 00 CARGA, 01 J1, 10 J2, 11 RESULT.
REQ-014 dup  output  1  one-cycle pulse marking a rejected duplicate; only with the REQ-030 macro.

Function
- REQ-015 State machine CARGA -> J1 -> J2 -> RESULT; RESULT holds until reset.
- REQ-016 CARGA: each insere stores numero in draw slot idx and increments idx.
  - After the N_PICKS-th store: next state J1, idx cleared.
  - fim and fim_jogo ignored.
- REQ-017 J1/J2 guess handling: each insere compares numero against all N_PICKS draw slots in parallel.
  - A match on a slot whose per-turn hit bit is clear sets that bit and increments the active player's score by exactly 1.
  - A number never scores twice in one turn.
  - Hit mask cleared on entry to J1 and to J2.
- REQ-018 Score latency: p1/p2 change in the cycle after the insere edge (registered).
- REQ-019 Turn end: the turn ends after N_PICKS accepted guesses or on fim, whichever comes first.
  - J1 -> J2; J2 -> RESULT.
- REQ-020 fim_jogo in J2: -> RESULT on the next edge; ignored in CARGA, J1 and RESULT.
- REQ-021 insere with fim or fim_jogo in the same cycle: the guess is scored first, then the turn or game ends.
- REQ-022 premio: registered on the transition into RESULT, valid in the first RESULT cycle, and 00 in all other states.
  - Comparison is unsigned, p1 against p2.
- REQ-023 insere in RESULT has no effect.
- REQ-024 Scores saturate at 2^CNT_W-1; no wrap-around.

Reset
- REQ-025 reset overrides all inputs in the same cycle, including mid-turn.
- REQ-026 Reset values:
  - estado=00 (CARGA), idx=0, guess count=0, hit mask=0.
  - p1=0, p2=0, premio=00, dup=0.
- REQ-027 Draw slot contents: unspecified after reset; overwritten during CARGA before use.

Configuration
- REQ-028 Macro LOTERIA_DUP_REJECT_EN compiles duplicate-guess rejection in or out.
- REQ-029 Macro undefined: every insere in J1/J2 counts toward N_PICKS, including repeats of earlier guesses; dup is tied to 0.
- REQ-030 Macro defined:
  - An insere in J1/J2 whose numero equals a guess already accepted this turn is not counted, not scored, and pulses dup for one cycle.
  - Per-turn guess history of N_PICKS entries is cleared at turn start.

Verification
- REQ-031 Load draws 5,3,8,2,0; P1 guesses 5,3,8,2,0 -> p1=5 after the 5th guess, estado=10.
- REQ-032 P1 guesses 1,4 then fim; P2 guesses 8,2,7,9,11 -> p1=0, p2=2, auto RESULT, premio=10.
- REQ-033 P1 guesses 5,5,5,5,5 with macro undefined -> p1=1, turn ends after 5 guesses.
  - Same stimulus with macro defined -> p1=1, dup pulses 4 times, still in J1.
- REQ-034 In J2 with p1=p2=1, assert fim_jogo -> estado=11, premio=11 in the next cycle.
- REQ-035 Assert reset in J2 with p1=3 -> next cycle p1=0, p2=0, estado=00, premio=00.
- REQ-036 NUM_W=6, N_PICKS=8, draws 0..7, P1 guesses 63,7,0 plus fim; fim_jogo asserted in J1 -> fim_jogo ignored in J1, p1=2 after P1's turn.
